// File: rtl/mips_pkg.sv
// Shared register-file write types for the 16-bit MIPS multicycle core.
package mips_pkg;

  localparam int REG_AW = 4;
  localparam int REG_DW = 16;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/wb_fifo2w1r.sv
// Two-write/one-read FIFO; port 0 is the older entry when both push together.
// Entry contents and read pointer are exported so the top can search them.
module wb_fifo2w1r
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0,
  input  wr_req_t       dat0,
  input  logic          push1,
  input  wr_req_t       dat1,
  input  logic          pop,
  output wr_req_t       head,
  output logic [2:0]    count,
  output wr_req_t       entries [DEPTH],
  output logic [PW-1:0] rd_ptr
);

  logic [PW-1:0] wr_ptr;
  wr_req_t       mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly PW bits wide, so the adds wrap modulo DEPTH.
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + 3'(push0) + 3'(push1) - 3'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push0)
        mem[wr_ptr] <= dat0;
      if (push1)
        mem[push0 ? wr_ptr + PW'(1) : wr_ptr] <= dat1;
    end
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;

endmodule

// File: rtl/reg_wb_queue.sv
// Register-file write queue merging ALU (A) and load (B) writes; REG_WB_FWD_EN adds bypass query ports.
// Latency: accept at edge N into an empty queue, wen/rwr/dwr driven after edge N+1.
// Backpressure: ready from registered count only; B needs two free slots while A is valid.
module reg_wb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DROP_R0 = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [3:0]    a_addr,
  input  logic [15:0]   a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [3:0]    b_addr,
  input  logic [15:0]   b_data,
  output logic [3:0]    rwr,
  output logic [15:0]   dwr,
  output logic          wen,
  output logic [2:0]    count,
`ifdef REG_WB_FWD_EN
  input  logic [3:0]    q_addr0,
  input  logic [3:0]    q_addr1,
  input  logic [3:0]    q_addr2,
  output logic          q_hit0,
  output logic          q_hit1,
  output logic          q_hit2,
  output logic [15:0]   q_data0,
  output logic [15:0]   q_data1,
  output logic [15:0]   q_data2,
`endif
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] LIM1 = 3'(DEPTH - 1);
  localparam logic [2:0] LIM2 = 3'(DEPTH - 2);

  wr_req_t       head;
  wr_req_t       entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic          a_push;
  logic          b_push;
  logic          pop;

  assign a_ready = (count <= LIM1);
  assign b_ready = a_valid ? (count <= LIM2) : (count <= LIM1);

  // Dropped r0 writes still handshake; they just never occupy a slot.
  assign a_push = a_valid && a_ready && !((DROP_R0 != 0) && (a_addr == REG_ZERO));
  assign b_push = b_valid && b_ready && !((DROP_R0 != 0) && (b_addr == REG_ZERO));
  assign pop    = (count != 3'd0);

  wb_fifo2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push0   (a_push),
    .dat0    ('{addr: a_addr, data: a_data}),
    .push1   (b_push),
    .dat1    ('{addr: b_addr, data: b_data}),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .entries (entries),
    .rd_ptr  (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wen <= 1'b0;
      rwr <= '0;
      dwr <= '0;
    end else if (pop) begin
      wen <= 1'b1;
      rwr <= head.addr;
      dwr <= head.data;
    end else begin
      wen <= 1'b0;
    end
  end

  assign busy = (count != 3'd0) || wen;

`ifdef REG_WB_FWD_EN
  logic [3:0]  qa [3];
  logic [2:0]  qh;
  logic [15:0] qd [3];

  assign qa[0] = q_addr0;
  assign qa[1] = q_addr1;
  assign qa[2] = q_addr2;

  // Search oldest to youngest so the last match wins; the output register is older than any entry.
  always_comb begin
    qh = '0;
    for (int k = 0; k < 3; k++) begin
      qd[k] = '0;
      if (wen && (rwr == qa[k])) begin
        qh[k] = 1'b1;
        qd[k] = dwr;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((3'(i) < count) && (entries[rd_ptr + PW'(i)].addr == qa[k])) begin
          qh[k] = 1'b1;
          qd[k] = entries[rd_ptr + PW'(i)].data;
        end
      end
      if ((DROP_R0 != 0) && (qa[k] == REG_ZERO)) begin
        qh[k] = 1'b0;
        qd[k] = '0;
      end
    end
  end

  assign q_hit0  = qh[0];
  assign q_hit1  = qh[1];
  assign q_hit2  = qh[2];
  assign q_data0 = qd[0];
  assign q_data1 = qd[1];
  assign q_data2 = qd[2];
`else
  logic unused_fwd;
  assign unused_fwd = ^{rd_ptr, entries[0]};
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Randomized bench for reg_wb_queue against a queue-based reference model, plus directed scenarios.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_addr, b_addr, rwr;
  logic [15:0] a_data, b_data, dwr;
  logic        wen, busy;
  logic [2:0]  count;
`ifdef REG_WB_FWD_EN
  logic [3:0]  q_addr0, q_addr1, q_addr2;
  logic        q_hit0, q_hit1, q_hit2;
  logic [15:0] q_data0, q_data1, q_data2;
`endif

  always #5 clk = ~clk;

  reg_wb_queue #(.DEPTH(DEPTH), .DROP_R0(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .rwr     (rwr),
    .dwr     (dwr),
    .wen     (wen),
    .count   (count),
`ifdef REG_WB_FWD_EN
    .q_addr0 (q_addr0),
    .q_addr1 (q_addr1),
    .q_addr2 (q_addr2),
    .q_hit0  (q_hit0),
    .q_hit1  (q_hit1),
    .q_hit2  (q_hit2),
    .q_data0 (q_data0),
    .q_data1 (q_data1),
    .q_data2 (q_data2),
`endif
    .busy    (busy)
  );

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_wen;
  logic [3:0]  m_rwr;
  logic [15:0] m_dwr;
  int          n_chk = 0;
  int          n_pass = 0;
  int          pushes = 0;
  int          wen_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_wen"}, 32'(wen), 32'(m_wen));
    chk({tag, "_rwr"}, 32'(rwr), 32'(m_rwr));
    chk({tag, "_dwr"}, 32'(dwr), 32'(m_dwr));
    chk({tag, "_busy"}, 32'(busy), 32'((mq.size() != 0) || m_wen));
  endtask

  // Drives one cycle at the negedge, checks ready, advances the model at posedge, checks outputs at next negedge.
  task automatic step(input logic r, input logic av, input logic [3:0] aa, input logic [15:0] ad,
                      input logic bv, input logic [3:0] ba, input logic [15:0] bd);
    logic er_a, er_b;
    ent_t e;
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    er_a = (mq.size() <= DEPTH - 1);
    er_b = av ? (mq.size() <= DEPTH - 2) : (mq.size() <= DEPTH - 1);
    chk("a_ready", 32'(a_ready), 32'(er_a));
    chk("b_ready", 32'(b_ready), 32'(er_b));
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_wen = 1'b0; m_rwr = '0; m_dwr = '0;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_wen = 1'b1; m_rwr = e.a; m_dwr = e.d;
      end else begin
        m_wen = 1'b0;
      end
      if (av && er_a && aa != 4'd0) begin mq.push_back('{aa, ad}); pushes++; end
      if (bv && er_b && ba != 4'd0) begin mq.push_back('{ba, bd}); pushes++; end
    end
    @(negedge clk);
    if (wen === 1'b1) wen_seen++;
    check_outputs("cyc");
  endtask

  task automatic idle();
    step(0, 0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
  endtask

  initial begin
    int w0, p0;
    rst = 1'b1; a_valid = 0; b_valid = 0;
    a_addr = 0; a_data = 0; b_addr = 0; b_data = 0;
`ifdef REG_WB_FWD_EN
    q_addr0 = 0; q_addr1 = 0; q_addr2 = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_wen = 0; m_rwr = 0; m_dwr = 0;
    check_outputs("reset");

    // Single ALU write to r3.
    step(1, 0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    step(0, 1, 4'd3, 16'h1234, 0, 4'd0, 16'd0);
    chk("t1_cnt1", 32'(count), 32'd1);
    idle();
    chk("t1_wen", 32'(wen), 32'd1);
    chk("t1_rwr", 32'(rwr), 32'd3);
    chk("t1_dwr", 32'(dwr), 32'h1234);
    idle();
    chk("t1_wen_off", 32'(wen), 32'd0);
    chk("t1_cnt0", 32'(count), 32'd0);

    // Same register from both sources: A first, B final.
    step(0, 1, 4'd5, 16'h00AA, 1, 4'd5, 16'h00BB);
    idle();
    chk("t2_first", 32'(dwr), 32'h00AA);
    idle();
    chk("t2_second_wen", 32'(wen), 32'd1);
    chk("t2_second", 32'(dwr), 32'h00BB);
    idle();
    chk("t2_hold", 32'(dwr), 32'h00BB);

    // Both sources held valid: occupancy saturates, B throttles first, one write per cycle.
    w0 = wen_seen; p0 = pushes;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 4'(1 + i % 15), 16'($urandom), 1, 4'(2 + i % 14), 16'($urandom));
      if (i >= 1) chk("t3_wen_each", 32'(wen), 32'd1);
    end
    chk("t3_sat", 32'(count), 32'd3);
    a_valid = 1; b_valid = 1; #1;
    chk("t3_b_throttled", 32'(b_ready), 32'd0);
    chk("t3_a_open", 32'(a_ready), 32'd1);
    repeat (6) idle();
    chk("t3_nolost", 32'(wen_seen - w0), 32'(pushes - p0));

    // r0 write is accepted and dropped.
    step(0, 1, 4'd0, 16'hFFFF, 0, 4'd0, 16'd0);
    chk("t4_cnt", 32'(count), 32'd0);
    idle();
    chk("t4_nowen", 32'(wen), 32'd0);

    // Reset while three entries are queued.
    step(0, 1, 4'd1, 16'h0101, 1, 4'd2, 16'h0202);
    step(0, 1, 4'd3, 16'h0303, 1, 4'd4, 16'h0404);
    chk("t5_cnt3", 32'(count), 32'd3);
    step(1, 0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    chk("t5_wen", 32'(wen), 32'd0);
    chk("t5_cnt", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t5_no_wen", 32'(wen), 32'd0);
    end

`ifdef REG_WB_FWD_EN
    step(0, 1, 4'd7, 16'h0001, 1, 4'd7, 16'h0002);
    q_addr0 = 4'd7; q_addr1 = 4'd8; q_addr2 = 4'd0; #1;
    chk("fwd_hit0", 32'(q_hit0), 32'd1);
    chk("fwd_data0", 32'(q_data0), 32'h0002);
    chk("fwd_hit1", 32'(q_hit1), 32'd0);
    chk("fwd_data1", 32'(q_data1), 32'd0);
    chk("fwd_r0", 32'(q_hit2), 32'd0);
    repeat (3) idle();
`endif

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), 16'($urandom),
           $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), 16'($urandom));
    end
    repeat (6) idle();
    chk("final_empty", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
